// File: rtl/pipe_issue_pkg.sv
// pipe_issue_pkg: opcodes, memory-port offsets, issue FSM states and the offset lookup
package pipe_issue_pkg;
  localparam logic [7:0] OP_NOP   = 8'd0;
  localparam logic [7:0] OP_MEM1  = 8'd1;
  localparam logic [7:0] OP_MEM2  = 8'd2;
  localparam logic [7:0] OP_ADD   = 8'd3;
  localparam logic [7:0] OP_MULT  = 8'd4;
  localparam logic [7:0] OP_WRITE = 8'd5;
  localparam logic [2:0] MEM1_OFS    = 3'd1;
  localparam logic [2:0] MEM2_OFS    = 3'd2;
  localparam logic [2:0] WRITE_OFS   = 3'd5;
  localparam logic [2:0] PIPE_STAGES = 3'd5;
  typedef enum logic {DRAIN, RUN} state_t;
  function automatic logic [2:0] mem_ofs(input logic [7:0] op);
    return op == OP_MEM1 ? MEM1_OFS : op == OP_MEM2 ? MEM2_OFS : op == OP_WRITE ? WRITE_OFS : 3'd0;
  endfunction
endpackage

// File: rtl/pipe_issue_fifo.sv
// pipe_issue_fifo: DEPTH x W synchronous FIFO with full/empty flags
module pipe_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_wr, do_rd;
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign rdata = mem[rp[AW-1:0]];
  // storage array, no reset needed since pointers gate visibility
  always_ff @(posedge clk)
    if (do_wr) mem[wp[AW-1:0]] <= wdata;
  // pointer advance; reset empties the queue
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/pipe_issue.sv
// pipe_issue: in-order issue stage with memory-port reservation; stats and shadow check under PIPE_ISSUE_STATS_EN
module pipe_issue
  import pipe_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_inst,
  output logic             in_ready,
  input  logic             issue_en,
  output logic [7:0]       inst,
  output logic             busy
`ifdef PIPE_ISSUE_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] issue_cnt
`endif
);
  localparam logic [5:0] R_MASK = 6'b111110;
  state_t state;
  logic [2:0] drain_cnt;
  logic [5:0] r, nr, d_bit;
  logic [7:0] head;
  logic full, empty, run, hazard, can_issue, bubble;
  assign run       = state == RUN;
  assign in_ready  = !full && run;
  assign busy      = !empty || !run;
  assign nr        = (r >> 1) & R_MASK;
  assign d_bit     = (6'd1 << mem_ofs(head)) & R_MASK;
  assign hazard    = |(nr & d_bit);
  assign can_issue = run && issue_en && !empty && !hazard;
  assign bubble    = run && issue_en && !empty && hazard;
  pipe_issue_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (in_valid && in_ready),
    .wdata (in_inst),
    .rd    (can_issue),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  // drain the reset-less pipeline, then issue head or a NOP while tracking port reservations
  always_ff @(posedge clk)
    if (reset) begin
      state     <= DRAIN;
      drain_cnt <= PIPE_STAGES;
      inst      <= OP_NOP;
      r         <= '0;
    end else begin
      inst <= can_issue ? head : OP_NOP;
      r    <= can_issue ? nr | d_bit : nr;
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt - 1'b1;
        if (drain_cnt == 3'd1) state <= RUN;
      end
    end
`ifdef PIPE_ISSUE_STATS_EN
  logic [7:0] sh [1:5];
  logic [1:0] sum_mem_access;
  assign sum_mem_access = {1'b0, sh[1] == OP_MEM1} + {1'b0, sh[2] == OP_MEM2} + {1'b0, sh[5] == OP_WRITE};
  // saturating bubble and issue counters
  always_ff @(posedge clk)
    if (reset) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (bubble && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (can_issue && head != OP_NOP && !(&issue_cnt)) issue_cnt <= issue_cnt + CNT_W'(1);
    end
  // shadow of the downstream stages, used only to check the port guarantee
  always_ff @(posedge clk)
    if (reset) begin
      for (int k = 1; k <= 5; k++) sh[k] <= OP_NOP;
    end else begin
      sh[1] <= inst;
      for (int k = 2; k <= 5; k++) sh[k] <= sh[k-1];
    end
`ifndef SYNTHESIS
  a_one_mem_access: assert property (@(posedge clk) disable iff (reset) sum_mem_access <= 2'd1);
`endif
`endif
endmodule
